// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer feeding HI/LO.
// Holds the pipeline (stall_req) while an op runs and writes HI/LO once.
// The multiply runs for MUL_LATENCY cycles. The divide is restoring, one bit per cycle.
// Optional feature: define MULDIV_FAST_DIVZERO_EN to finish DIV/DIVU by zero
// in one cycle (HI=src1, LO=all ones). Without it, all iterations run.
module hilo_muldiv_ctrl #(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_ITERS   = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        cancel,
  input  logic        stall,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        whilo_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [4:0] MUL_LOAD = 5'(MUL_LATENCY - 1);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_ITERS - 1);

  state_t      state, state_nx;
  logic        accept, fast_dz, op_signed;
  logic        is_signed_q, q_neg_q, r_neg_q;
  logic [4:0]  cnt_q;
  logic [31:0] a_q, b_q, rem_q;
  logic [31:0] res_hi_q, res_lo_q, hi_q, lo_q;
  logic [31:0] src1_mag, src2_mag;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [31:0] div_rem_nx, div_quo_nx;
  logic [63:0] mul_a, mul_b, mul_prod;

  // An op is taken only from IDLE, and a cancel in the same cycle wins over it.
  assign accept    = (state == S_IDLE) && start && !cancel;
  assign op_signed = !op[0];
  assign src1_mag  = (op_signed && src1[31]) ? -src1 : src1;
  assign src2_mag  = (op_signed && src2[31]) ? -src2 : src2;

`ifdef MULDIV_FAST_DIVZERO_EN
  assign fast_dz = op[1] && (src2 == 32'd0);
`else
  assign fast_dz = 1'b0;
`endif

  // One restoring-division step. The 33-bit compare also covers the case
  // where the shifted remainder overflows 32 bits.
  assign div_shift  = {rem_q, a_q[31]};
  assign div_diff   = div_shift - {1'b0, b_q};
  assign div_ge     = (div_shift >= {1'b0, b_q});
  assign div_rem_nx = div_ge ? div_diff[31:0] : div_shift[31:0];
  assign div_quo_nx = {a_q[30:0], div_ge};

  // Sign- or zero-extend the operands so that one 64x64 multiply serves both MULT and MULTU.
  assign mul_a    = is_signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign mul_b    = is_signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign mul_prod = mul_a * mul_b;

  // State register.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state and strobe logic.
  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_nx  = state;
    whilo_out = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = !op[1] ? S_MUL : (fast_dz ? S_DONE : S_DIV);
      S_MUL:  if (cnt_q == 5'd0) state_nx = S_DONE;
      S_DIV:  if (cnt_q == 5'd0) state_nx = S_DONE;
      S_DONE: if (!stall) begin
        state_nx  = S_IDLE;
        whilo_out = !cancel;
      end
      default: state_nx = S_IDLE;
    endcase
    if (cancel) state_nx = S_IDLE;
  end

  assign stall_req = accept || (state == S_MUL) || (state == S_DIV);
  assign busy      = (state != S_IDLE);

  // Operand latch, iteration counter and the multiply/divide datapath.
  // NOTE: pure datapath flops carry no reset; the FSM never reads them before an accept loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_signed_q <= op_signed;
      q_neg_q     <= op_signed && (src1[31] ^ src2[31]);
      r_neg_q     <= op_signed && src1[31];
      rem_q       <= 32'd0;
      if (op[1]) begin
        cnt_q <= DIV_LOAD;
        a_q   <= src1_mag;
        b_q   <= src2_mag;
      end else begin
        cnt_q <= MUL_LOAD;
        a_q   <= src1;
        b_q   <= src2;
      end
      if (fast_dz) begin
        res_hi_q <= src1;
        res_lo_q <= 32'hFFFF_FFFF;
      end
    end else if (state == S_MUL) begin
      cnt_q <= cnt_q - 5'd1;
      if (cnt_q == 5'd0) begin
        res_hi_q <= mul_prod[63:32];
        res_lo_q <= mul_prod[31:0];
      end
    end else if (state == S_DIV) begin
      cnt_q <= cnt_q - 5'd1;
      rem_q <= div_rem_nx;
      a_q   <= div_quo_nx;
      if (cnt_q == 5'd0) begin
        res_hi_q <= r_neg_q ? -div_rem_nx : div_rem_nx;
        res_lo_q <= q_neg_q ? -div_quo_nx : div_quo_nx;
      end
    end
  end

  // Committed HI/LO. The new value is presented during the write cycle and then held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (whilo_out) begin
      hi_q <= res_hi_q;
      lo_q <= res_lo_q;
    end
  end

  assign hi_out = whilo_out ? res_hi_q : hi_q;
  assign lo_out = whilo_out ? res_lo_q : lo_q;

endmodule
